// File: rtl/bet_entry.sv
// bet_entry: collects one roulette bet from single-cycle button pulses.
// The player first sets a stake bounded by the balance latched at round start,
// then picks 1-4 distinct numbers with a wrapping cursor. The finished bet is
// offered downstream with a bet_valid/bet_ack handshake and held afterwards so
// later stages can still sample it.

module bet_entry #(
    parameter logic [15:0] AMT_STEP = 16'd10,
    parameter logic [5:0]  MAX_NUM  = 6'd36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_next,
    input  logic        btn_confirm,
    input  logic        bet_ack,
    input  logic [15:0] current_money,
    output logic [1:0]  state,
    output logic [15:0] bet_amount,
    output logic [2:0]  bet_count,
    output logic [23:0] bet_nums,
    output logic [5:0]  cursor,
    output logic        bet_valid,
    output logic        dup_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AMOUNT  = 2'd1,
        NUMBERS = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Only one button may act per cycle; this is the winner after priority.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CONFIRM,
        ACT_NEXT,
        ACT_UP,
        ACT_DOWN
    } action_t;

    state_t      state_q;
    action_t     action;
    logic [15:0] money_snap;
    logic [15:0] min_amt;
    logic [15:0] start_amt;
    logic [16:0] up_sum;
    logic [15:0] amt_up;
    logic [15:0] amt_down;
    logic [15:0] down_diff;
    logic [5:0]  cursor_up;
    logic [5:0]  cursor_down;
    logic        is_dup;
    logic        slots_full;
    logic [23:0] nums_insert;

    assign state = state_q;

    // Resolve simultaneous buttons: confirm beats next beats up beats down.
    always_comb begin
        action = ACT_NONE;
        if (btn_confirm)
            action = ACT_CONFIRM;
        else if (btn_next)
            action = ACT_NEXT;
        else if (btn_up)
            action = ACT_UP;
        else if (btn_down)
            action = ACT_DOWN;
    end

    // Stake bounds: the floor is one step, or the whole balance if smaller.
    always_comb begin
        min_amt   = (money_snap < AMT_STEP) ? money_snap : AMT_STEP;
        start_amt = (current_money < AMT_STEP) ? current_money : AMT_STEP;
    end

    // Stake after an up press, summed one bit wider so it can never wrap.
    always_comb begin
        up_sum = {1'b0, bet_amount} + {1'b0, AMT_STEP};
        if (up_sum > {1'b0, money_snap})
            amt_up = money_snap;
        else
            amt_up = up_sum[15:0];
    end

    // Stake after a down press, clamped at the floor including on underflow.
    always_comb begin
        down_diff = bet_amount - AMT_STEP;
        if (bet_amount < AMT_STEP)
            amt_down = min_amt;
        else if (down_diff < min_amt)
            amt_down = min_amt;
        else
            amt_down = down_diff;
    end

    // Cursor movement with wrap-around across 0..MAX_NUM.
    always_comb begin
        cursor_up   = (cursor >= MAX_NUM) ? 6'd0 : cursor + 6'd1;
        cursor_down = (cursor == 6'd0) ? MAX_NUM : cursor - 6'd1;
    end

    // Check the cursor against every occupied slot and prepare the slot write.
    always_comb begin
        is_dup     = 1'b0;
        slots_full = (bet_count >= 3'd4);
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < bet_count) && (bet_nums[6*i +: 6] == cursor))
                is_dup = 1'b1;
        end
        nums_insert = bet_nums;
        nums_insert[6*bet_count[1:0] +: 6] = cursor;
    end

    // Main bet-entry state machine; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            money_snap <= 16'd0;
            bet_amount <= 16'd0;
            bet_count  <= 3'd0;
            bet_nums   <= 24'hFFFFFF;
            cursor     <= 6'd0;
            bet_valid  <= 1'b0;
            dup_err    <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (current_money != 16'd0)) begin
                        money_snap <= current_money;
                        bet_amount <= start_amt;
                        bet_count  <= 3'd0;
                        bet_nums   <= 24'hFFFFFF;
                        state_q    <= AMOUNT;
                    end
                end
                AMOUNT: begin
                    case (action)
                        ACT_CONFIRM: begin
                            cursor  <= 6'd0;
                            state_q <= NUMBERS;
                        end
                        ACT_UP:   bet_amount <= amt_up;
                        ACT_DOWN: bet_amount <= amt_down;
                        default: ;
                    endcase
                end
                NUMBERS: begin
                    case (action)
                        ACT_CONFIRM: begin
                            if (bet_count != 3'd0) begin
                                bet_valid <= 1'b1;
                                state_q   <= DONE;
                            end
                        end
                        ACT_NEXT: begin
                            if (is_dup || slots_full) begin
                                dup_err <= 1'b1;
                            end else begin
                                bet_nums  <= nums_insert;
                                bet_count <= bet_count + 3'd1;
                            end
                        end
                        ACT_UP:   cursor <= cursor_up;
                        ACT_DOWN: cursor <= cursor_down;
                        default: ;
                    endcase
                end
                DONE: begin
                    if (bet_ack) begin
                        bet_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bet_entry.sv
// tb_bet_entry: directed scenarios plus random button traffic, each cycle
// compared against a queue-based behavioural model of the bet rules.

module tb_bet_entry;

    localparam int STEP = 10;
    localparam int MAXN = 36;

    // Button vector layout: {start, up, down, next, confirm, ack}
    localparam logic [5:0] B_NONE    = 6'b000000;
    localparam logic [5:0] B_START   = 6'b100000;
    localparam logic [5:0] B_UP      = 6'b010000;
    localparam logic [5:0] B_DOWN    = 6'b001000;
    localparam logic [5:0] B_NEXT    = 6'b000100;
    localparam logic [5:0] B_CONFIRM = 6'b000010;
    localparam logic [5:0] B_ACK     = 6'b000001;

    logic        clk;
    logic        rst;
    logic        start;
    logic        btn_up;
    logic        btn_down;
    logic        btn_next;
    logic        btn_confirm;
    logic        bet_ack;
    logic [15:0] current_money;
    logic [1:0]  state;
    logic [15:0] bet_amount;
    logic [2:0]  bet_count;
    logic [23:0] bet_nums;
    logic [5:0]  cursor;
    logic        bet_valid;
    logic        dup_err;

    int n_compared;
    int n_mismatched;

    // Reference model state
    int m_state;
    int m_snap;
    int m_amt;
    int m_cursor;
    bit m_valid;
    bit m_dup;
    int m_nums[$];

    bet_entry #(
        .AMT_STEP(16'd10),
        .MAX_NUM (6'd36)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_next     (btn_next),
        .btn_confirm  (btn_confirm),
        .bet_ack      (bet_ack),
        .current_money(current_money),
        .state        (state),
        .bet_amount   (bet_amount),
        .bet_count    (bet_count),
        .bet_nums     (bet_nums),
        .cursor       (cursor),
        .bet_valid    (bet_valid),
        .dup_err      (dup_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_snap   = 0;
        m_amt    = 0;
        m_cursor = 0;
        m_valid  = 0;
        m_dup    = 0;
        m_nums.delete();
    endtask

    // Bet rules in plain arithmetic: one step per clock with the given inputs.
    task automatic model_step(input logic [5:0] b, input int money);
        bit s, u, d, n, c, a;
        int min_amt;
        bit dup;
        {s, u, d, n, c, a} = b;
        m_dup = 0;
        case (m_state)
            0: begin
                if (s && money != 0) begin
                    m_snap  = money;
                    m_amt   = (money < STEP) ? money : STEP;
                    m_nums.delete();
                    m_state = 1;
                end
            end
            1: begin
                min_amt = (m_snap < STEP) ? m_snap : STEP;
                if (c) begin
                    m_cursor = 0;
                    m_state  = 2;
                end else if (n) begin
                end else if (u) begin
                    m_amt = m_amt + STEP;
                    if (m_amt > m_snap) m_amt = m_snap;
                end else if (d) begin
                    m_amt = m_amt - STEP;
                    if (m_amt < min_amt) m_amt = min_amt;
                end
            end
            2: begin
                if (c) begin
                    if (m_nums.size() > 0) begin
                        m_state = 3;
                        m_valid = 1;
                    end
                end else if (n) begin
                    dup = 0;
                    foreach (m_nums[i]) if (m_nums[i] == m_cursor) dup = 1;
                    if (!dup && m_nums.size() < 4)
                        m_nums.push_back(m_cursor);
                    else
                        m_dup = 1;
                end else if (u) begin
                    m_cursor = (m_cursor + 1) % (MAXN + 1);
                end else if (d) begin
                    m_cursor = (m_cursor + MAXN) % (MAXN + 1);
                end
            end
            default: begin
                if (a) begin
                    m_valid = 0;
                    m_state = 0;
                end
            end
        endcase
    endtask

    task automatic compareModel(input string tag);
        logic [23:0] exp_nums;
        exp_nums = 24'hFFFFFF;
        for (int i = 0; i < m_nums.size(); i++)
            exp_nums[6*i +: 6] = 6'(m_nums[i]);
        checkOutput({tag, ".state"},  32'(state),      32'(m_state));
        checkOutput({tag, ".amount"}, 32'(bet_amount), 32'(m_amt));
        checkOutput({tag, ".count"},  32'(bet_count),  32'(m_nums.size()));
        checkOutput({tag, ".nums"},   32'(bet_nums),   32'(exp_nums));
        checkOutput({tag, ".cursor"}, 32'(cursor),     32'(m_cursor));
        checkOutput({tag, ".valid"},  32'(bet_valid),  32'(m_valid));
        checkOutput({tag, ".dup"},    32'(dup_err),    32'(m_dup));
    endtask

    // Drive one cycle of pulses, advance model and DUT, then compare.
    task automatic applyStimulus(input string tag, input logic [5:0] b);
        {start, btn_up, btn_down, btn_next, btn_confirm, bet_ack} = b;
        model_step(b, int'(current_money));
        @(posedge clk);
        #1;
        compareModel(tag);
        {start, btn_up, btn_down, btn_next, btn_confirm, bet_ack} = B_NONE;
    endtask

    task automatic repeatStimulus(input string tag, input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, b);
    endtask

    initial begin
        logic [5:0] rb;
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b0;
        {start, btn_up, btn_down, btn_next, btn_confirm, bet_ack} = B_NONE;
        current_money = 16'd0;
        model_reset();

        @(posedge clk);
        #1;
        compareModel("reset");
        checkOutput("reset_nums", 32'(bet_nums), 32'h00FFFFFF);
        rst = 1'b1;

        // Basic bet
        current_money = 16'd100;
        applyStimulus("basic", B_START);
        repeatStimulus("basic", B_UP, 3);
        applyStimulus("basic", B_CONFIRM);
        repeatStimulus("basic", B_UP, 5);
        applyStimulus("basic", B_NEXT);
        applyStimulus("basic", B_CONFIRM);
        checkOutput("basic_amt",   32'(bet_amount), 32'd40);
        checkOutput("basic_count", 32'(bet_count),  32'd1);
        checkOutput("basic_nums",  32'(bet_nums),   32'h00FFFFC5);
        checkOutput("basic_valid", 32'(bet_valid),  32'd1);
        applyStimulus("basic_up_in_done", B_UP);
        checkOutput("done_hold_amt", 32'(bet_amount), 32'd40);
        applyStimulus("basic", B_ACK);
        checkOutput("basic_ack_valid", 32'(bet_valid), 32'd0);
        checkOutput("basic_ack_state", 32'(state),     32'd0);

        // Stake clamping against a small balance
        current_money = 16'd25;
        applyStimulus("clamp25", B_START);
        current_money = 16'd5000;
        repeatStimulus("clamp25", B_UP, 5);
        checkOutput("clamp25_hi", 32'(bet_amount), 32'd25);
        repeatStimulus("clamp25", B_DOWN, 5);
        checkOutput("clamp25_lo", 32'(bet_amount), 32'd10);
        applyStimulus("clamp25", B_CONFIRM);
        applyStimulus("clamp25", B_NEXT);
        applyStimulus("clamp25", B_CONFIRM);
        applyStimulus("clamp25", B_ACK);

        current_money = 16'd7;
        applyStimulus("clamp7", B_START);
        repeatStimulus("clamp7", B_UP, 3);
        repeatStimulus("clamp7", B_DOWN, 3);
        checkOutput("clamp7_amt", 32'(bet_amount), 32'd7);

        // Cursor wrap, duplicate and full-slot rejection
        applyStimulus("nums", B_CONFIRM);
        applyStimulus("nums_empty_confirm", B_CONFIRM);
        checkOutput("empty_confirm_state", 32'(state), 32'd2);
        applyStimulus("nums", B_DOWN);
        checkOutput("wrap_down", 32'(cursor), 32'd36);
        applyStimulus("nums", B_NEXT);
        applyStimulus("nums_dup", B_NEXT);
        checkOutput("dup_pulse", 32'(dup_err),   32'd1);
        checkOutput("dup_count", 32'(bet_count), 32'd1);
        applyStimulus("nums_dup_clear", B_NONE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("nums", B_UP);
            applyStimulus("nums", B_NEXT);
        end
        applyStimulus("nums", B_UP);
        applyStimulus("nums_full", B_NEXT);
        checkOutput("full_pulse", 32'(dup_err),   32'd1);
        checkOutput("full_count", 32'(bet_count), 32'd4);
        applyStimulus("nums", B_CONFIRM);
        applyStimulus("nums", B_ACK);

        // Same-cycle confirm and up in AMOUNT, then start with no money
        current_money = 16'd100;
        applyStimulus("prio", B_START);
        applyStimulus("prio", B_CONFIRM | B_UP);
        checkOutput("prio_amt",   32'(bet_amount), 32'd10);
        checkOutput("prio_state", 32'(state),      32'd2);
        applyStimulus("prio", B_NEXT);
        applyStimulus("prio", B_CONFIRM);
        applyStimulus("prio", B_ACK);
        current_money = 16'd0;
        applyStimulus("nomoney", B_START);
        checkOutput("nomoney_state", 32'(state), 32'd0);

        // Asynchronous reset mid-round with two slots filled
        current_money = 16'd100;
        applyStimulus("rstmid", B_START);
        applyStimulus("rstmid", B_CONFIRM);
        applyStimulus("rstmid", B_NEXT);
        applyStimulus("rstmid", B_UP);
        applyStimulus("rstmid", B_NEXT);
        checkOutput("rstmid_count", 32'(bet_count), 32'd2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compareModel("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus("after_rst", B_START);
        checkOutput("after_rst_state", 32'(state), 32'd1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 4))
                    0: current_money = 16'd0;
                    1: current_money = 16'd7;
                    2: current_money = 16'd25;
                    3: current_money = 16'd100;
                    default: current_money = 16'($urandom_range(0, 10000));
                endcase
            end
            rb[5] = ($urandom_range(0, 99) < 10);
            rb[4] = ($urandom_range(0, 99) < 30);
            rb[3] = ($urandom_range(0, 99) < 20);
            rb[2] = ($urandom_range(0, 99) < 20);
            rb[1] = ($urandom_range(0, 99) < 8);
            rb[0] = ($urandom_range(0, 99) < 15);
            applyStimulus("rand", rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bet_entry.md
# bet_entry

Upstream bet-collection stage for the roulette datapath. Takes debounced single-cycle button pulses from the input stage and builds one bet: a stake amount bounded by the player's current balance, plus 1–4 distinct roulette numbers (0–36). Presents the bet to the round controller and balance-update stage (`bet_amount`, `bet_count`, `bet_nums`) with a valid/ack handshake. Holds the presented values stable until the next round starts.

## Interface
- `AMT_STEP`, default 16'd10: stake increment/decrement per button press.
- `MAX_NUM`, default 6'd36: highest roulette number; the cursor range is 0..MAX_NUM.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Assertion immediately forces reset values; release is synchronous to `clk`.
- `start` in 1: 1-cycle pulse from the round controller that begins bet entry.
- `btn_up` / `btn_down` in 1 each: 1-cycle pulses that increase or decrease the stake or the cursor.
- `btn_next` in 1: 1-cycle pulse that commits the cursor number to the next bet slot.
- `btn_confirm` in 1: 1-cycle pulse that ends the current phase.
- `bet_ack` in 1: 1-cycle pulse from the consumer accepting the bet.
- `current_money` in 16: current balance, range 0..10000.
- `state` out 2: 0 = IDLE, 1 = AMOUNT, 2 = NUMBERS, 3 = DONE.
- `bet_amount` out 16: stake.
- `bet_count` out 3: number of committed slots, 0..4.
- `bet_nums` out 24: slot i occupies bits [6i+5:6i]; an unused slot reads 6'h3F.
- `cursor` out 6: currently selected number, used by the display.
- `bet_valid` out 1: bet is complete and stable; level signal.
- `dup_err` out 1: 1-cycle pulse on a rejected commit.

## Operation
- Reset values: `state`=IDLE, `bet_amount`=0, `bet_count`=0, `bet_nums`=24'hFFFFFF, `cursor`=0, `bet_valid`=0, `dup_err`=0, `money_snap`=0.
- Button priority within one cycle: `btn_confirm` > `btn_next` > `btn_up` > `btn_down`. Only the highest-priority button present acts; the others are dropped.

**IDLE**
- `start` with `current_money`≠0: latch `money_snap`=`current_money`.
  - Set `bet_amount` = min(AMT_STEP, money_snap).
  - Clear `bet_count` and `bet_nums`.
  - Go to AMOUNT.
- `start` with `current_money`=0: ignored; stay in IDLE.
- Button presses and `bet_ack` are ignored in IDLE.
- All outputs keep their last values, so the downstream stage can still sample the previous bet.

**AMOUNT**
- Define min_amt = min(AMT_STEP, money_snap).
- `btn_up`: `bet_amount` = min(bet_amount+AMT_STEP, money_snap). Compute the sum at 17 bits; no wrap.
- `btn_down`: `bet_amount` = max(bet_amount−AMT_STEP, min_amt). Any underflow is clamped to min_amt.
- `btn_confirm`: set `cursor`=0 and go to NUMBERS.
- `btn_next`: ignored.
- Later changes to `current_money` do not affect the bounds, because they come from `money_snap`.

**NUMBERS**
- `btn_up`: `cursor`+1, wrapping from MAX_NUM to 0.
- `btn_down`: `cursor`−1, wrapping from 0 to MAX_NUM.
- `btn_next`, accepted when `bet_count`<4 and `cursor` matches no occupied slot:
  - Write `cursor` into slot `bet_count`.
  - Increment `bet_count`.
- `btn_next`, rejected when the number is a duplicate or `bet_count`=4:
  - Pulse `dup_err` for 1 cycle.
  - No slot change.
- `btn_confirm` with `bet_count`≥1: go to DONE and set `bet_valid`=1.
- `btn_confirm` with `bet_count`=0: ignored.

**DONE**
- `bet_valid` stays high and all bet outputs are frozen.
- `bet_ack`: clear `bet_valid` and go to IDLE. The bet outputs are retained.
- Buttons and `start` are ignored.

**General**
- `start` outside IDLE and `bet_ack` outside DONE are ignored.
- Reset asserted mid-round returns to the reset values immediately, in any state.

## Timing
- Every response is registered: an input pulse in cycle N produces the output change visible in cycle N+1.
- `bet_valid` rises 1 cycle after the accepting `btn_confirm` and falls 1 cycle after `bet_ack`.
- `bet_ack` is accepted in the same cycle that `bet_valid` is first visible high.
- `bet_amount`, `bet_count` and `bet_nums` never change while `bet_valid`=1.
- `dup_err` is high for exactly 1 cycle, the cycle after the rejected `btn_next`.
- Throughput: at most one button action per cycle. Back-to-back pulses on consecutive cycles are each honoured.

## Test plan
- **Basic bet:** reset, `current_money`=100, `start`, 3×`btn_up`, `btn_confirm`, 5×`btn_up`, `btn_next`, `btn_confirm`
  - Expect `bet_amount`=40, `bet_count`=1, `bet_nums`[5:0]=5, `bet_nums`[23:6] all ones.
  - Expect `bet_valid`=1 one cycle after the final confirm, then low after `bet_ack`.
- **Stake clamping:** `current_money`=25, `start`, 5×`btn_up` → `bet_amount`=25. Then 5×`btn_down` → `bet_amount`=10.
  - Also: `current_money`=7 → `bet_amount` stays at 7 under any up/down.
- **Cursor wrap and duplicates:** in NUMBERS, `btn_down` from 0 → `cursor`=36.
  - Commit 36, then `btn_next` again → `dup_err` pulses and `bet_count` stays 1.
  - Commit 4 distinct numbers, then a fifth `btn_next` → `dup_err` pulses and `bet_count`=4.
- **Ignored inputs:** `btn_confirm` with `bet_count`=0 → stay in NUMBERS.
  - `start` with `current_money`=0 → stay in IDLE.
  - `btn_up` in DONE → outputs unchanged.
  - `btn_confirm` and `btn_up` in the same cycle while in AMOUNT → only the confirm acts.
- **Reset mid-round:** drop `rst` low asynchronously in NUMBERS with `bet_count`=2.
  - All outputs return to their reset values without waiting for a clock edge.
  - After release, a new `start` works normally.
